adc_sample_writer: RTL and testbench

Upstream stage of master_wrapper. Accepts the 16-bit ADC/sine sample stream, packs sample pairs into 32-bit words and buffers them in a small FIFO. It then issues single-word write requests on the mdriver_int master side (32-bit data, 9-bit address) into a circular window of aximem. It reports half/full-window events and dropped samples to the cpu.

---
 rtl/adc_wr_pkg.sv | 25 ++
 rtl/adc_sample_writer_if.sv | 13 +
 rtl/adc_sample_writer_sync_fifo.sv | 57 +++++
 rtl/adc_sample_writer.sv | 161 ++++++++++++++++
 tb/tb_adc_sample_writer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_wr_pkg.sv
// Shared types, widths and helpers for the ADC sample writer.
package adc_wr_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned SMP_W  = DATA_W / 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {IDLE, REQ} state_e;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] waddr_t;
  typedef logic [SMP_W-1:0]  smp_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    waddr_t addr;
    word_t  data;
  } wr_req_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_sample_writer_if.sv
// Single-word write request channel towards the memory master driver.
interface adc_sample_writer_if;
  import adc_wr_pkg::*;

  logic   m_req;
  logic   m_we;
  waddr_t m_addr;
  word_t  m_wdata;
  logic   m_ack;

  modport master (output m_req, m_we, m_addr, m_wdata, input m_ack);
  modport slave  (input m_req, m_we, m_addr, m_wdata, output m_ack);
endinterface

// File: rtl/adc_sample_writer_sync_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             wr_en, rd_en;

  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
  assign head_c  = mem_q[rd_q[IDX_W-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign rd_en = pop & ~empty_c;
  assign wr_en = push & (~full_c | rd_en);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q[IDX_W-1:0]] = push_data;
      wr_d = wr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_d = rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/adc_sample_writer.sv
// Packs 16-bit sample pairs into words, buffers them and writes them
// one at a time into a circular memory window, reporting window events.
module adc_sample_writer
  import adc_wr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter waddr_t      BASE_ADDR  = 9'h100,
  parameter int unsigned BUF_WORDS  = 64
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       enable,
  input  logic                       smp_valid,
  input  smp_t                       smp_data,
  output logic                       smp_ready,
  adc_sample_writer_if.master        m_if,
  output waddr_t                     wr_ptr,
  output cnt_t                       wrap_count,
  output cnt_t                       drop_count,
  output logic                       half_irq,
  output logic                       full_irq
);

  localparam waddr_t LAST_ADDR = waddr_t'(32'(BASE_ADDR) + BUF_WORDS - 32'd1);
  localparam waddr_t HALF_ADDR = waddr_t'(32'(BASE_ADDR) + BUF_WORDS / 32'd2 - 32'd1);

  logic    half_q, half_d;
  smp_t    low_q, low_d;
  word_t   word_q, word_d;
  logic    push_q, push_d;
  state_e  state_q, state_d;
  logic    m_req_q, m_req_d;
  wr_req_t req_q, req_d;
  waddr_t  wr_ptr_q, wr_ptr_d;
  cnt_t    wrap_q, wrap_d;
  cnt_t    drop_q, drop_d;
  logic    half_irq_q, half_irq_d;
  logic    full_irq_q, full_irq_d;

  logic    fifo_pop;
  word_t   fifo_head;
  logic    fifo_full, fifo_empty;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push_q),
    .push_data (word_q),
    .pop       (fifo_pop),
    .head_c    (fifo_head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // Sample packer: first sample parks in the low half, second completes the word.
  always_comb begin
    half_d = half_q;
    low_d  = low_q;
    word_d = word_q;
    push_d = 1'b0;
    if (!enable) begin
      half_d = 1'b0;
    end else if (smp_valid) begin
      if (half_q) begin
        word_d = {smp_data, low_q};
        push_d = 1'b1;
        half_d = 1'b0;
      end else begin
        low_d  = smp_data;
        half_d = 1'b1;
      end
    end
  end

  // Write FSM; returning to IDLE after each ack gives the one-cycle request gap.
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    req_d      = req_q;
    wr_ptr_d   = wr_ptr_q;
    wrap_d     = wrap_q;
    drop_d     = drop_q;
    half_irq_d = 1'b0;
    full_irq_d = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = REQ;
          m_req_d    = 1'b1;
          req_d.addr = wr_ptr_q;
          req_d.data = fifo_head;
        end
      end
      REQ: begin
        if (m_if.m_ack) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          fifo_pop   = 1'b1;
          half_irq_d = (req_q.addr == HALF_ADDR);
          full_irq_d = (req_q.addr == LAST_ADDR);
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = BASE_ADDR;
            wrap_d   = sat_inc(wrap_q);
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
    if (push_q && fifo_full && !fifo_pop) begin
      drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      half_q     <= 1'b0;
      low_q      <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      req_q      <= '{addr: BASE_ADDR, data: '0};
      wr_ptr_q   <= BASE_ADDR;
      wrap_q     <= '0;
      drop_q     <= '0;
      half_irq_q <= 1'b0;
      full_irq_q <= 1'b0;
    end else begin
      half_q     <= half_d;
      low_q      <= low_d;
      word_q     <= word_d;
      push_q     <= push_d;
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      wrap_q     <= wrap_d;
      drop_q     <= drop_d;
      half_irq_q <= half_irq_d;
      full_irq_q <= full_irq_d;
    end
  end

  assign smp_ready    = enable;
  assign m_if.m_req   = m_req_q;
  assign m_if.m_we    = m_req_q;
  assign m_if.m_addr  = req_q.addr;
  assign m_if.m_wdata = req_q.data;
  assign wr_ptr       = wr_ptr_q;
  assign wrap_count   = wrap_q;
  assign drop_count   = drop_q;
  assign half_irq     = half_irq_q;
  assign full_irq     = full_irq_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// Directed bench for adc_sample_writer: packing, ring addressing, irqs, drops, reset.
module tb_adc_sample_writer;
  import adc_wr_pkg::*;

  logic   clk       = 1'b0;
  logic   nreset    = 1'b0;
  logic   enable    = 1'b0;
  logic   smp_valid = 1'b0;
  smp_t   smp_data  = '0;
  logic   m_ack     = 1'b0;
  logic   smp_ready;
  waddr_t wr_ptr;
  cnt_t   wrap_count, drop_count;
  logic   half_irq, full_irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adc_sample_writer_if m_if ();
  assign m_if.m_ack = m_ack;

  adc_sample_writer #(
    .FIFO_DEPTH (4),
    .BASE_ADDR  (9'h100),
    .BUF_WORDS  (64)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .enable     (enable),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .smp_ready  (smp_ready),
    .m_if       (m_if),
    .wr_ptr     (wr_ptr),
    .wrap_count (wrap_count),
    .drop_count (drop_count),
    .half_irq   (half_irq),
    .full_irq   (full_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    nreset = 1'b0;
    m_ack  = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    tick();
  endtask

  task automatic send_sample(input smp_t d);
    smp_valid = 1'b1;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic wait_req(input int limit, output bit ok);
    int n = 0;
    while (m_if.m_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    ok = (m_if.m_req === 1'b1);
    if (!ok) chk("req_timeout", 32'(m_if.m_req), 32'd1);
  endtask

  // Wait for a request, check it, acknowledge after 'delay' cycles.
  task automatic ack_word(input string tag, input waddr_t exp_addr, input word_t exp_data,
                          input int delay);
    bit ok;
    wait_req(60, ok);
    if (ok) begin
      chk({tag, "_addr"}, 32'(m_if.m_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, m_if.m_wdata, exp_data);
      chk({tag, "_we"}, 32'(m_if.m_we), 32'd1);
      repeat (delay) tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      chk({tag, "_req_drop"}, 32'(m_if.m_req), 32'd0);
    end
  endtask

  initial begin
    reset_dut();

    // Reset values
    chk("rst_req", 32'(m_if.m_req), 32'd0);
    chk("rst_we", 32'(m_if.m_we), 32'd0);
    chk("rst_addr", 32'(m_if.m_addr), 32'h100);
    chk("rst_wdata", m_if.m_wdata, 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'h100);
    chk("rst_wrap", 32'(wrap_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_half", 32'(half_irq), 32'd0);
    chk("rst_full", 32'(full_irq), 32'd0);
    chk("rst_ready", 32'(smp_ready), 32'd0);

    // Single pair, ack two cycles after request
    enable = 1'b1;
    tick();
    chk("t1_ready", 32'(smp_ready), 32'd1);
    send_sample(16'h0001);
    send_sample(16'h0002);
    ack_word("t1", 9'h100, 32'h0002_0001, 2);
    chk("t1_wr_ptr", 32'(wr_ptr), 32'h101);

    // Full window pass with immediate acks
    reset_dut();
    enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 128; i++) send_sample(16'(i));
      end
      begin
        for (int k = 0; k < 64; k++) begin
          ack_word("t2", 9'(32'h100 + k), {16'(2 * k + 1), 16'(2 * k)}, 0);
          chk("t2_half_irq", 32'(half_irq), 32'(k == 31));
          chk("t2_full_irq", 32'(full_irq), 32'(k == 63));
        end
      end
    join
    chk("t2_wr_ptr", 32'(wr_ptr), 32'h100);
    chk("t2_wrap", 32'(wrap_count), 32'd1);
    chk("t2_drop", 32'(drop_count), 32'd0);

    // Acks stalled while 6 words arrive: 4 held (head in flight), 2 dropped
    for (int i = 0; i < 12; i++) send_sample(16'(32'h3000 + i));
    repeat (4) tick();
    chk("t3_drop", 32'(drop_count), 32'd2);
    for (int k = 0; k < 4; k++)
      ack_word("t3", 9'(32'h100 + k), {16'(32'h3000 + 2 * k + 1), 16'(32'h3000 + 2 * k)}, 0);
    repeat (3) tick();
    chk("t3_idle", 32'(m_if.m_req), 32'd0);
    chk("t3_wr_ptr", 32'(wr_ptr), 32'h104);

    // Odd sample discarded when enable falls
    send_sample(16'hA001);
    send_sample(16'hA002);
    send_sample(16'hA003);
    enable = 1'b0;
    tick();
    chk("t4_ready", 32'(smp_ready), 32'd0);
    ack_word("t4a", 9'h104, 32'hA002_A001, 1);
    repeat (4) tick();
    chk("t4_no_extra", 32'(m_if.m_req), 32'd0);
    enable = 1'b1;
    send_sample(16'hA004);
    send_sample(16'hA005);
    ack_word("t4b", 9'h105, 32'hA005_A004, 0);
    chk("t4_wr_ptr", 32'(wr_ptr), 32'h106);

    // Reset while a request is outstanding
    send_sample(16'hB001);
    send_sample(16'hB002);
    begin
      bit ok;
      wait_req(20, ok);
    end
    nreset = 1'b0;
    #1;
    chk("t5_req", 32'(m_if.m_req), 32'd0);
    chk("t5_we", 32'(m_if.m_we), 32'd0);
    chk("t5_wr_ptr", 32'(wr_ptr), 32'h100);
    chk("t5_wrap", 32'(wrap_count), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    chk("t5_addr", 32'(m_if.m_addr), 32'h100);
    tick();
    tick();
    nreset = 1'b1;
    tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    repeat (3) tick();
    chk("t5_late_ack_req", 32'(m_if.m_req), 32'd0);
    chk("t5_late_ack_ptr", 32'(wr_ptr), 32'h100);

    // Drop counter saturation: 270 words, 4 held, 266 dropped
    enable = 1'b1;
    for (int i = 0; i < 540; i++) send_sample(16'(i));
    repeat (4) tick();
    chk("t6_drop_sat", 32'(drop_count), 32'hFF);
    for (int k = 0; k < 4; k++)
      ack_word("t6", 9'(32'h100 + k), {16'(2 * k + 1), 16'(2 * k)}, 0);
    repeat (3) tick();
    chk("t6_wr_ptr", 32'(wr_ptr), 32'h104);
    chk("t6_drop_hold", 32'(drop_count), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
